// File: rtl/stack_ctrl.sv
// stack_ctrl: sequencer in front of a hardware word stack.
// It accepts PUSH/POP/CALL/RET and PUSHN/POPN burst requests and turns them
// into registered single-cycle stack strobes. It keeps its own copy of the
// stack depth so that overflow and underflow are flagged instead of being
// dropped silently. Popped words come back on a valid/ready response port.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   req_vld/req_rdy/req_op/req_data/req_cnt
//                                    request channel (op codes 0..5, 6-7 illegal)
//   wr_vld/wr_rdy/wr_data            burst push beat channel (PUSHN)
//   rsp_vld/rsp_rdy/rsp_data/rsp_ret/rsp_err/rsp_last
//                                    popped-word response channel
//   stk_push/stk_pop/stk_wdata/stk_rdata
//                                    downstream stack (updates on negedge clk)
//   depth                            words currently on the stack
//   err_ovf/err_unf/err_ill/err_clr  sticky error flags and their clear
module stack_ctrl #(
  parameter int DEPTH = 1024,
  parameter int DW    = 32,
  parameter int CW    = 4,
  localparam int AW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic [2:0]    req_op,
  input  logic [DW-1:0] req_data,
  input  logic [CW-1:0] req_cnt,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [DW-1:0] wr_data,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_ret,
  output logic          rsp_err,
  output logic          rsp_last,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_wdata,
  input  logic [DW-1:0] stk_rdata,
  output logic [AW-1:0] depth,
  output logic          err_ovf,
  output logic          err_unf,
  output logic          err_ill,
  input  logic          err_clr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PUSHB = 2'd1;
  localparam logic [1:0] S_POPI  = 2'd2;
  localparam logic [1:0] S_RSP   = 2'd3;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_CALL  = 3'd2;
  localparam logic [2:0] OP_RET   = 3'd3;
  localparam logic [2:0] OP_PUSHN = 3'd4;
  localparam logic [2:0] OP_POPN  = 3'd5;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ret_q, ret_d;
  logic          unf_q, unf_d;     // pop issued for the current word underflowed
  logic          push_q, push_d, pop_q, pop_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rvld_q, rvld_d, rret_q, rret_d, rerr_q, rerr_d, rlast_q, rlast_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] depth_q, depth_d;
  logic          ovf_q, unf_flag_q, ill_q;
  logic          set_ovf, set_unf, set_ill;
  logic          can_push, can_pop;

  assign can_push = depth_q < AW'(DEPTH);
  assign can_pop  = depth_q != '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    unf_d   = unf_q;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    wdata_d = wdata_q;
    rvld_d  = rvld_q;
    rret_d  = rret_q;
    rerr_d  = rerr_q;
    rlast_d = rlast_q;
    rdata_d = rdata_q;
    depth_d = depth_q;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    set_ill = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_vld) begin
          case (req_op)
            OP_PUSH, OP_CALL: begin
              if (can_push) begin
                push_d  = 1'b1;
                wdata_d = req_data;
                depth_d = depth_q + AW'(1);
              end else begin
                set_ovf = 1'b1;
              end
            end
            OP_POP, OP_RET, OP_POPN: begin
              cnt_d   = (req_op == OP_POPN) ? req_cnt : '0;
              ret_d   = (req_op == OP_RET);
              state_d = S_POPI;
              // The pop strobe is registered so it is high exactly in POPI.
              if (can_pop) begin
                pop_d   = 1'b1;
                depth_d = depth_q - AW'(1);
                unf_d   = 1'b0;
              end else begin
                set_unf = 1'b1;
                unf_d   = 1'b1;
              end
            end
            OP_PUSHN: begin
              cnt_d   = req_cnt;
              state_d = S_PUSHB;
            end
            default: set_ill = 1'b1;
          endcase
        end
      end
      S_PUSHB: begin
        if (wr_vld) begin
          // Beats past a full stack are still consumed, just dropped.
          if (can_push) begin
            push_d  = 1'b1;
            wdata_d = wr_data;
            depth_d = depth_q + AW'(1);
          end else begin
            set_ovf = 1'b1;
          end
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      S_POPI: begin
        // Stack presented the word at the negedge inside this cycle.
        rvld_d  = 1'b1;
        rdata_d = unf_q ? '0 : stk_rdata;
        rerr_d  = unf_q;
        rlast_d = (cnt_q == '0);
        rret_d  = ret_q;
        state_d = S_RSP;
      end
      default: begin // S_RSP
        if (rsp_rdy) begin
          rvld_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q - CW'(1);
            state_d = S_POPI;
            if (can_pop) begin
              pop_d   = 1'b1;
              depth_d = depth_q - AW'(1);
              unf_d   = 1'b0;
            end else begin
              set_unf = 1'b1;
              unf_d   = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ret_q      <= 1'b0;
      unf_q      <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      wdata_q    <= '0;
      rvld_q     <= 1'b0;
      rret_q     <= 1'b0;
      rerr_q     <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
      depth_q    <= '0;
      ovf_q      <= 1'b0;
      unf_flag_q <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ret_q      <= ret_d;
      unf_q      <= unf_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      wdata_q    <= wdata_d;
      rvld_q     <= rvld_d;
      rret_q     <= rret_d;
      rerr_q     <= rerr_d;
      rlast_q    <= rlast_d;
      rdata_q    <= rdata_d;
      depth_q    <= depth_d;
      // A new error in the same cycle as err_clr wins over the clear.
      ovf_q      <= (ovf_q      & ~err_clr) | set_ovf;
      unf_flag_q <= (unf_flag_q & ~err_clr) | set_unf;
      ill_q      <= (ill_q      & ~err_clr) | set_ill;
    end
  end

  assign req_rdy   = (state_q == S_IDLE);
  assign wr_rdy    = (state_q == S_PUSHB);
  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_wdata = wdata_q;
  assign rsp_vld   = rvld_q;
  assign rsp_data  = rdata_q;
  assign rsp_ret   = rret_q;
  assign rsp_err   = rerr_q;
  assign rsp_last  = rlast_q;
  assign depth     = depth_q;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_flag_q;
  assign err_ill   = ill_q;

endmodule
